// File: rtl/hc595_chain_tx_if.sv
// Word handshake between display-pattern logic and the 74HC595 chain transmitter.
interface hc595_chain_tx_if #(
    parameter int unsigned W = 16
) ();
    logic [W-1:0] in_data;
    logic         in_lsb_first;
    logic         in_valid;
    logic         in_ready;

    modport master (
        output in_data,
        output in_lsb_first,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_lsb_first,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/hc595_chain_tx.sv
// Serialises one full-chain word into a daisy-chain of 74HC595s, then pulses st_cp to latch.
// sh_cp/st_cp run at CLK_DIV clk cycles per half-period; all pin outputs are registered.
module hc595_chain_tx #(
    parameter int unsigned NUM_CHIPS = 2,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                clk,
    input  logic                rst,
    hc595_chain_tx_if.slave     up,
    output logic                done,
    output logic                sh_cp,
    output logic                st_cp,
    output logic                ds
);
    localparam int unsigned W    = 8 * NUM_CHIPS;
    localparam int unsigned CntW = $clog2(W);

    localparam logic [7:0]      PhaseLast = 8'(CLK_DIV - 1);
    localparam logic [CntW-1:0] BitLast   = CntW'(W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatchLo,
        StLatchHi,
        StDone
    } state_t;

    state_t          state;
    logic [7:0]      phase;
    logic [CntW-1:0] bit_cnt;
    logic [W-1:0]    shreg;
    logic            lsb_first;
    logic            ready_q;

    logic         accept;
    logic         phase_end;
    logic [W-1:0] shifted;

    assign up.in_ready = ready_q;

    always_comb begin
        accept    = up.in_valid && ready_q;
        phase_end = (phase == PhaseLast);
        shifted   = lsb_first ? {1'b0, shreg[W-1:1]} : {shreg[W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            lsb_first <= 1'b0;
            ready_q   <= 1'b1;
            done      <= 1'b0;
            sh_cp     <= 1'b0;
            st_cp     <= 1'b0;
            ds        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                // DONE accepts exactly like IDLE so back-to-back frames have no gap.
                StIdle, StDone: begin
                    if (accept) begin
                        state     <= StShiftLo;
                        phase     <= '0;
                        bit_cnt   <= '0;
                        shreg     <= up.in_data;
                        lsb_first <= up.in_lsb_first;
                        ready_q   <= 1'b0;
                        ds        <= up.in_lsb_first ? up.in_data[0] : up.in_data[W-1];
                    end else begin
                        state   <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                StShiftLo: begin
                    if (phase_end) begin
                        phase <= '0;
                        sh_cp <= 1'b1;
                        state <= StShiftHi;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                StShiftHi: begin
                    if (phase_end) begin
                        phase <= '0;
                        sh_cp <= 1'b0;
                        shreg <= shifted;
                        if (bit_cnt == BitLast) begin
                            state <= StLatchLo;
                            ds    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= StShiftLo;
                            ds      <= lsb_first ? shifted[0] : shifted[W-1];
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                StLatchLo: begin
                    if (phase_end) begin
                        phase <= '0;
                        st_cp <= 1'b1;
                        state <= StLatchHi;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                StLatchHi: begin
                    if (phase_end) begin
                        phase   <= '0;
                        st_cp   <= 1'b0;
                        done    <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= StDone;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hc595_chain_tx.sv
// Drives three chain configurations and checks each against a behavioural 74HC595 model:
// latched value, frame length, latch-pulse placement and pin-level invariants.
module tb_hc595_chain_tx;
    function automatic int chips_of(int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int div_of(int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic        rst_a   [3];
    logic        valid_a [3];
    logic        lsb_a   [3];
    logic [63:0] data_a  [3];
    logic        ready_a [3];
    logic        sh_a    [3];
    logic        st_a    [3];
    logic        ds_a    [3];
    logic        done_a  [3];
    logic [63:0] latched_a [3];
    int          rises_a [3];
    int          pulses_a[3];
    int          viol_a  [3];

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int Chips = chips_of(g);
        localparam int Div   = div_of(g);

        hc595_chain_tx_if #(.W(8 * Chips)) bus ();
        logic        sh, st, ds, done;
        logic [63:0] sr      = '0;
        logic [63:0] latched = '0;
        int          rises   = 0;
        int          pulses  = 0;
        int          viol    = 0;
        logic        sh_q    = 1'b0;
        logic        ds_q    = 1'b0;
        logic        done_q  = 1'b0;

        assign bus.in_data      = data_a[g][8*Chips-1:0];
        assign bus.in_lsb_first = lsb_a[g];
        assign bus.in_valid     = valid_a[g];
        assign ready_a[g]       = bus.in_ready;
        assign sh_a[g]          = sh;
        assign st_a[g]          = st;
        assign ds_a[g]          = ds;
        assign done_a[g]        = done;
        assign latched_a[g]     = latched;
        assign rises_a[g]       = rises;
        assign pulses_a[g]      = pulses;
        assign viol_a[g]        = viol;

        hc595_chain_tx #(.NUM_CHIPS(Chips), .CLK_DIV(Div)) dut (
            .clk   (clk),
            .rst   (rst_a[g]),
            .up    (bus),
            .done  (done),
            .sh_cp (sh),
            .st_cp (st),
            .ds    (ds)
        );

        // The chain behaves as one long shift register; the first bit in ends up farthest.
        always @(posedge sh) begin
            sr    <= {sr[62:0], ds};
            rises <= rises + 1;
        end

        always @(posedge st) begin
            latched <= sr;
            pulses  <= pulses + 1;
        end

        always @(posedge clk) begin
            if ((sh && st) || (sh && sh_q && ds != ds_q) || (done && done_q)) viol <= viol + 1;
            sh_q   <= sh;
            ds_q   <= ds;
            done_q <= done;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expect_latch(logic [63:0] word, bit lsb, int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[lsb ? (w - 1 - i) : i] = word[i];
        return r;
    endfunction

    function automatic bit idle_ok(int g);
        return !sh_a[g] && !st_a[g] && !ds_a[g] && !done_a[g] && ready_a[g];
    endfunction

    // Entered and left on a negedge; leaves valid high when hold=1 for gap-free chaining.
    task automatic send_frame(input int g, input logic [63:0] word, input bit lsb, input bit hold,
                              output int acc, output int dn);
        int          w, cd, r0, p0, st_first, st_cnt, waited, i;
        bit          busy_bad;
        logic [63:0] mask;
        w    = 8 * chips_of(g);
        cd   = div_of(g);
        mask = {64{1'b1}} >> (64 - w);
        data_a[g]  = word;
        lsb_a[g]   = lsb;
        valid_a[g] = 1'b1;
        waited = 0;
        while (!ready_a[g] && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", ready_a[g], 1);
        acc = 0;
        dn  = 0;
        if (!ready_a[g]) begin
            valid_a[g] = 1'b0;
            return;
        end
        r0 = rises_a[g];
        p0 = pulses_a[g];
        @(negedge clk);
        acc = cyc;
        data_a[g] = {$urandom, $urandom};
        if (!hold) begin
            valid_a[g] = 1'b0;
            lsb_a[g]   = 1'($urandom);
        end
        st_first = -1;
        st_cnt   = 0;
        busy_bad = 1'b0;
        for (i = 0; i < 20000; i++) begin
            if (done_a[g]) break;
            if (ready_a[g]) busy_bad = 1'b1;
            if (st_a[g]) begin
                if (st_first < 0) st_first = i;
                st_cnt++;
            end
            @(negedge clk);
        end
        dn = cyc;
        check("frame_len", i, 2 * cd * (w + 1));
        check("busy_ready", busy_bad, 0);
        check("st_cnt", st_cnt, cd);
        check("st_pos", st_first, 2 * cd * w + cd);
        check("sh_rises", rises_a[g] - r0, w);
        check("st_pulses", pulses_a[g] - p0, 1);
        check("latch", latched_a[g] & mask, expect_latch(word & mask, lsb, w));
        check("done_ready", ready_a[g], 1);
    endtask

    initial begin
        int          acc1, dn1, acc2, dn2, r0, p0, waited;
        bit          bad;
        logic [63:0] lat0;
        for (int g = 0; g < 3; g++) begin
            rst_a[g]   = 1'b1;
            valid_a[g] = 1'b0;
            lsb_a[g]   = 1'b0;
            data_a[g]  = '0;
        end

        @(posedge clk);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!idle_ok(0)) bad = 1'b1;
        end
        check("reset_outputs", bad, 0);
        for (int g = 0; g < 3; g++) rst_a[g] = 1'b0;

        r0  = rises_a[0];
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (!idle_ok(0)) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);
        check("idle_no_rise", rises_a[0] - r0, 0);

        send_frame(0, 64'hA5C3, 1'b0, 1'b0, acc1, dn1);
        @(negedge clk);
        check("done_one_cycle", done_a[0], 0);
        send_frame(0, 64'hA5C3, 1'b1, 1'b0, acc1, dn1);
        @(negedge clk);

        r0 = rises_a[0];
        p0 = pulses_a[0];
        send_frame(0, 64'hFFFF, 1'b0, 1'b1, acc1, dn1);
        send_frame(0, 64'h0001, 1'b0, 1'b0, acc2, dn2);
        check("b2b_no_gap", acc2, dn1 + 1);
        check("b2b_rises", rises_a[0] - r0, 32);
        check("b2b_pulses", pulses_a[0] - p0, 2);
        @(negedge clk);

        lat0 = latched_a[0];
        p0   = pulses_a[0];
        r0   = rises_a[0];
        data_a[0]  = 64'($urandom);
        lsb_a[0]   = 1'b0;
        valid_a[0] = 1'b1;
        waited = 0;
        while ((rises_a[0] - r0) < 7 && waited < 2000) begin
            @(negedge clk);
            waited++;
            if (!ready_a[0]) valid_a[0] = 1'b0;
        end
        check("rst_mid_rises", rises_a[0] - r0, 7);
        rst_a[0] = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", idle_ok(0), 1);
        rst_a[0] = 1'b0;
        repeat (80) @(negedge clk);
        check("rst_mid_no_latch", pulses_a[0] - p0, 0);
        check("rst_mid_latched", latched_a[0], lat0);
        send_frame(0, 64'($urandom), 1'($urandom), 1'b0, acc1, dn1);

        for (int g = 1; g < 3; g++) begin
            for (int k = 0; k < 4; k++) begin
                send_frame(g, {$urandom, $urandom}, 1'($urandom), 1'($urandom_range(0, 1)),
                           acc1, dn1);
            end
            valid_a[g] = 1'b0;
            @(negedge clk);
        end

        for (int g = 0; g < 3; g++) check("pin_invariants", viol_a[g], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
